// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON block sequencer: memory geometry,
// job limits, FSM state encoding and the job-length acceptance check.
package ascon_pkg;

  localparam int unsigned MEM_WORDS  = 32;
  localparam int unsigned MAX_BLOCKS = 16;
  localparam int unsigned AW         = $clog2(MEM_WORDS);

  typedef enum logic [3:0] {
    IDLE,
    START,
    WAIT_REQ,
    FETCH_LO,
    FETCH_HI,
    PRESENT,
    WB_LO,
    WB_HI,
    WAIT_TAG,
    DONE
  } seq_state_e;

  // A job fits when AD + PT blocks (6-bit sum, no wrap) is at most MAX_BLOCKS.
  function automatic logic len_ok(input logic [4:0] ad, input logic [4:0] pt);
    return ({1'b0, ad} + {1'b0, pt}) <= 6'(MAX_BLOCKS);
  endfunction

endpackage

// File: rtl/ascon_block_seq_if.sv
// Host SRAM access bus.
//   req   : host access request (held until gnt)
//   we    : write when set, read otherwise
//   addr  : word address
//   wdata : write data
//   gnt   : access performed this cycle
// master = host side, slave = arbiter side.
interface ascon_block_seq_if;

  logic                     req;
  logic                     we;
  logic [ascon_pkg::AW-1:0] addr;
  logic [31:0]              wdata;
  logic                     gnt;

  modport master (output req, output we, output addr, output wdata, input gnt);
  modport slave  (input req, input we, input addr, input wdata, output gnt);

endinterface

// File: rtl/ascon_mem_arb.sv
// Single-port SRAM arbiter. The sequencer has absolute priority while it
// owns the port; otherwise a host request passes straight through and is
// granted in the same cycle.
//   port_en   : port usable (low blocks every access, e.g. during reset)
//   seq_own   : sequencer owns the port this cycle
//   seq_we/seq_addr/seq_wdata : sequencer access
//   host      : host bus (slave side)
//   mem_*     : SRAM control outputs
module ascon_mem_arb
  import ascon_pkg::*;
(
  input  logic          port_en,
  input  logic          seq_own,
  input  logic          seq_we,
  input  logic [AW-1:0] seq_addr,
  input  logic [31:0]   seq_wdata,
  ascon_block_seq_if.slave host,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata
);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    host.gnt  = 1'b0;
    if (port_en) begin
      if (seq_own) begin
        mem_en    = 1'b1;
        mem_we    = seq_we;
        mem_addr  = seq_addr;
        mem_wdata = seq_wdata;
      end else if (host.req) begin
        mem_en    = 1'b1;
        mem_we    = host.we;
        mem_addr  = host.addr;
        mem_wdata = host.wdata;
        host.gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ascon_block_seq.sv
// ASCON block sequencer: streams AD then PT blocks from a 32x32 SRAM to
// the cipher core as 64-bit {hi, lo} blocks, writes returned ciphertext
// back in place over the PT words, and waits for the tag.
//   wb_clk_i, wb_rst_ni : clock, async active-low reset
//   go, ad_blocks, pt_blocks : job start and lengths
//   host_*      : host SRAM access, shared with the sequencer
//   mem_*       : SRAM port (read data one cycle after a read)
//   core_start, block_request, blk_data, blk_valid : core input side
//   CTblock, CTv, Tv : core output side (ciphertext block, tag valid)
//   busy, done, err_len, err_ovr : status
module ascon_block_seq
  import ascon_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        go,
  input  logic [4:0]  ad_blocks,
  input  logic [4:0]  pt_blocks,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [4:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        mem_en,
  output logic        mem_we,
  output logic [4:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        core_start,
  input  logic        block_request,
  output logic [63:0] blk_data,
  output logic        blk_valid,
  input  logic [63:0] CTblock,
  input  logic        CTv,
  input  logic        Tv,
  output logic        busy,
  output logic        done,
  output logic        err_len,
  output logic        err_ovr
);

  seq_state_e state_q, state_d, ret_q;

  logic [4:0]  ad_q, pt_q, k_q, total;
  logic [31:0] lo_q;
  logic [63:0] blk_data_q;
  logic        blk_valid_q;
  logic [63:0] ct_data_q;
  logic [4:0]  ct_blk_q, ct_cnt_q;
  logic        ct_pending_q, tag_seen_q;
  logic        err_len_q, err_ovr_q;

  logic        go_acc, go_rej;
  logic        seq_own, seq_we;
  logic [AW-1:0] seq_addr;
  logic [31:0] seq_wdata;

  assign total  = ad_q + pt_q;
  assign go_acc = (state_q == IDLE) && go && len_ok(ad_blocks, pt_blocks);
  assign go_rej = (state_q == IDLE) && go && !len_ok(ad_blocks, pt_blocks);

  always_comb begin
    state_d   = state_q;
    seq_own   = 1'b0;
    seq_we    = 1'b0;
    seq_addr  = '0;
    seq_wdata = '0;
    case (state_q)
      IDLE:     if (go_acc) state_d = START;
      START:    state_d = (total == 5'd0) ? WAIT_TAG : WAIT_REQ;
      WAIT_REQ: begin
        if (ct_pending_q)       state_d = WB_LO;
        else if (block_request) state_d = FETCH_LO;
      end
      FETCH_LO: begin
        seq_own  = 1'b1;
        seq_addr = AW'({k_q, 1'b0});
        state_d  = FETCH_HI;
      end
      FETCH_HI: begin
        seq_own  = 1'b1;
        seq_addr = AW'({k_q, 1'b1});
        state_d  = PRESENT;
      end
      // First PRESENT cycle captures hi; the handshake is only honoured
      // once blk_valid is up.
      PRESENT: begin
        if (blk_valid_q && block_request)
          state_d = ((k_q + 5'd1) == total) ? WAIT_TAG : WAIT_REQ;
      end
      WB_LO: begin
        seq_own   = 1'b1;
        seq_we    = 1'b1;
        seq_addr  = AW'({ct_blk_q, 1'b0});
        seq_wdata = ct_data_q[31:0];
        state_d   = WB_HI;
      end
      WB_HI: begin
        seq_own   = 1'b1;
        seq_we    = 1'b1;
        seq_addr  = AW'({ct_blk_q, 1'b1});
        seq_wdata = ct_data_q[63:32];
        state_d   = ret_q;
      end
      WAIT_TAG: begin
        if (ct_pending_q)          state_d = WB_LO;
        else if (tag_seen_q || Tv) state_d = DONE;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      ret_q        <= IDLE;
      ad_q         <= '0;
      pt_q         <= '0;
      k_q          <= '0;
      lo_q         <= '0;
      blk_data_q   <= '0;
      blk_valid_q  <= 1'b0;
      ct_data_q    <= '0;
      ct_blk_q     <= '0;
      ct_cnt_q     <= '0;
      ct_pending_q <= 1'b0;
      tag_seen_q   <= 1'b0;
      err_len_q    <= 1'b0;
      err_ovr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_len_q <= go_rej;
      if ((state_q != WB_LO) && (state_d == WB_LO)) ret_q <= state_q;

      if (go_acc) begin
        ad_q         <= ad_blocks;
        pt_q         <= pt_blocks;
        k_q          <= '0;
        ct_cnt_q     <= '0;
        ct_pending_q <= 1'b0;
        tag_seen_q   <= 1'b0;
        err_ovr_q    <= 1'b0;
      end

      case (state_q)
        FETCH_HI: lo_q <= mem_rdata;
        PRESENT: begin
          if (!blk_valid_q) begin
            blk_data_q  <= {mem_rdata, lo_q};
            blk_valid_q <= 1'b1;
          end else if (block_request) begin
            blk_data_q  <= '0;
            blk_valid_q <= 1'b0;
            k_q         <= k_q + 5'd1;
          end
        end
        WB_HI:   ct_pending_q <= 1'b0;
        default: ;
      endcase

      // Every CT pulse advances the PT ordinal, even a dropped one, so later
      // blocks still land over their own source words.
      if (state_q != IDLE) begin
        if (Tv) tag_seen_q <= 1'b1;
        if (CTv) begin
          ct_cnt_q <= ct_cnt_q + 5'd1;
          if (ct_pending_q) begin
            err_ovr_q <= 1'b1;
          end else begin
            ct_data_q    <= CTblock;
            ct_blk_q     <= ad_q + ct_cnt_q;
            ct_pending_q <= 1'b1;
          end
        end
      end
    end
  end

  ascon_block_seq_if host_bus ();

  assign host_bus.req   = host_req;
  assign host_bus.we    = host_we;
  assign host_bus.addr  = host_addr;
  assign host_bus.wdata = host_wdata;
  assign host_gnt       = host_bus.gnt;

  ascon_mem_arb u_arb (
    .port_en   (wb_rst_ni),
    .seq_own   (seq_own),
    .seq_we    (seq_we),
    .seq_addr  (seq_addr),
    .seq_wdata (seq_wdata),
    .host      (host_bus.slave),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  assign core_start = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign blk_data   = blk_data_q;
  assign blk_valid  = blk_valid_q;
  assign err_len    = err_len_q;
  assign err_ovr    = err_ovr_q;

endmodule

// File: doc/ascon_block_seq.md
ASCON_BLOCK_SEQ -- requirements
Module: ascon_block_seq

Interface
REQ-001 The module SHALL use one clock and one reset, wb_clk_i (rising edge) and wb_rst_ni; the reset SHALL be asynchronous and active-low.
REQ-002 Ports SHALL be, in order (name  dir  width  meaning):
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  async active-low reset
- go  in  1  one-cycle job start pulse
- ad_blocks  in  5  number of 64-bit AD blocks
- pt_blocks  in  5  number of 64-bit PT blocks
- host_req  in  1  host memory access request
- host_we  in  1  host write
- host_addr  in  5  host word address
- host_wdata  in  32  host write data
- host_gnt  out  1  host access performed this cycle
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write
- mem_addr  out  5  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid 1 cycle after mem_en & ~mem_we
- core_start  out  1  one-cycle core start pulse
- block_request  in  1  core wants the next input block (level)
- blk_data  out  64  block to core, {hi word, lo word}
- blk_valid  out  1  blk_data valid; transfer when blk_valid & block_request
- CTblock  in  64  ciphertext block from core
- CTv  in  1  CTblock valid, single cycle
- Tv  in  1  tag valid, single cycle
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- err_len  out  1  one-cycle length error pulse
- err_ovr  out  1  sticky CT overrun, cleared by next accepted go

Function
REQ-003 FSM states SHALL be IDLE, START, WAIT_REQ, FETCH_LO, FETCH_HI, PRESENT, WB_LO, WB_HI, WAIT_TAG, DONE.
REQ-004 In IDLE, go with ad_blocks+pt_blocks <= 16 (6-bit sum) SHALL latch both lengths, clear the block index and err_ovr, and enter START; busy=1 from the next cycle.
REQ-005 go with sum > 16 SHALL pulse err_len the next cycle and remain IDLE; go outside IDLE SHALL be ignored.
REQ-006 START SHALL assert core_start for exactly one cycle, then enter WAIT_REQ, or WAIT_TAG if both lengths are 0.
REQ-007 Block k (0-based, AD blocks first, then PT) SHALL occupy words 2k (lo) and 2k+1 (hi).
REQ-008 WAIT_REQ: a pending CT write SHALL go to WB_LO first; otherwise block_request=1 SHALL go to FETCH_LO.
REQ-009 FETCH_LO SHALL read 2k, FETCH_HI SHALL read 2k+1 and capture lo, and PRESENT SHALL capture hi; blk_valid SHALL rise 3 cycles after block_request is sampled in WAIT_REQ.
REQ-010 PRESENT SHALL hold blk_valid and blk_data until blk_valid & block_request, then increment k and return to WAIT_REQ, or go to WAIT_TAG once k equals the total block count.
REQ-011 CTv SHALL capture CTblock and a PT block index into a one-entry buffer and set ct_pending in any non-IDLE state; CTv while ct_pending=1 SHALL set err_ovr and discard the new block.
REQ-012 WB_LO/WB_HI SHALL write CT lo/hi in place over the source PT words, clear ct_pending after WB_HI, and return to the calling state.
REQ-013 WAIT_TAG SHALL drain a pending CT first; Tv (latched if it arrives early) with ct_pending=0 SHALL enter DONE.
REQ-014 DONE SHALL pulse done for one cycle and return to IDLE with busy=0.
REQ-015 The sequencer SHALL own the SRAM port in FETCH_LO, FETCH_HI, WB_LO and WB_HI; otherwise host_req SHALL be forwarded to the SRAM combinationally with host_gnt=1 in the same cycle.
REQ-016 host_gnt SHALL be 0 while the sequencer owns the port; the host SHALL hold its request until granted.
REQ-017 blk_data SHALL be zero whenever blk_valid=0.

Reset
REQ-018 Asserting wb_rst_ni low at any time, including mid-job, SHALL force IDLE and set all outputs, buffers, counters and flags to 0 with no SRAM write; the job is abandoned.

Structure
REQ-019 The state enum, MEM_WORDS=32 and MAX_BLOCKS=16 SHALL live in ascon_pkg.
REQ-020 The SRAM port mux and grant logic SHALL be one sub-module, ascon_mem_arb; everything else SHALL be flat.

Verification
REQ-021 ad=1, pt=2, words 0..5 = 0x1..0x6: three fetches SHALL yield blk_data 0x2_1, 0x4_3, 0x6_5; CTv blocks SHALL land at words 2..5; Tv SHALL give done one cycle later.
REQ-022 go with ad=10, pt=7: err_len SHALL pulse, busy SHALL stay 0, and core_start SHALL never pulse.
REQ-023 host_req held during FETCH_LO/FETCH_HI: host_gnt SHALL be 0 for those 2 cycles and 1 in the PRESENT cycle.
REQ-024 Two CTv pulses without an intervening write-back: err_ovr SHALL set, the first CT SHALL be written, and the second SHALL be dropped.
REQ-025 wb_rst_ni low during WB_HI: mem_we SHALL drop immediately; after release the block SHALL be IDLE and a new go SHALL work.
REQ-026 ad=0, pt=0: core_start, then Tv SHALL give done with zero SRAM accesses.
